// File: rtl/mem_port_ctrl.sv
// Memory port controller: arbitrates a fetch port and a data port onto one
// unified memory, checks alignment/range, and extends sub-word loads.
module mem_port_ctrl #(
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   // fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_instr,
   // data port
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [1:0]  dm_size,
   input  logic        dm_unsigned,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ack,
   output logic        dm_err,
   output logic [31:0] dm_rdata,
   // memory port
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_half,
   output logic        mem_byte,
   output logic        mem_fetch,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

   state_e      state_q, state_d;
   logic        last_data_q;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic        we_q, uns_q, err_q;
   logic        if_ack_q, if_err_q, dm_ack_q, dm_err_q;
   logic [31:0] if_instr_q, dm_rdata_q;

   logic        grant_f, grant_d;
   logic        f_pend, d_pend;
   logic        f_err, d_err;
   logic [2:0]  d_nb_m1;
   logic [32:0] f_last, d_last;
   logic [31:0] load_ext;
   logic        in_fetch, in_data;

   // Access legality, evaluated on the request fields at grant time.
   always_comb begin
      f_last = {1'b0, if_addr} + 33'd3;
      f_err  = (if_addr[1:0] != 2'b00) || (f_last >= 33'(MEM_BYTES));
      unique case (dm_size)
         2'b00:   d_nb_m1 = 3'd0;
         2'b01:   d_nb_m1 = 3'd1;
         default: d_nb_m1 = 3'd3;
      endcase
      d_last = {1'b0, dm_addr} + {30'b0, d_nb_m1};
      d_err  = (dm_size == 2'b11)
            || ((dm_size == 2'b01) && dm_addr[0])
            || ((dm_size == 2'b10) && (dm_addr[1:0] != 2'b00))
            || (d_last >= 33'(MEM_BYTES));
   end

   // Next state and arbitration; a source being acked this cycle is ignored.
   always_comb begin
      state_d = state_q;
      grant_f = 1'b0;
      grant_d = 1'b0;
      f_pend  = if_req && !if_ack_q;
      d_pend  = dm_req && !dm_ack_q;
      unique case (state_q)
         StIdle: begin
            if (f_pend && (!d_pend || last_data_q)) begin
               grant_f = 1'b1;
               state_d = StFetch;
            end else if (d_pend) begin
               grant_d = 1'b1;
               state_d = StData;
            end
         end
         StFetch: state_d = StIdle;
         StData:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Memory strobes come purely from state and captured fields.
   always_comb begin
      in_fetch  = (state_q == StFetch);
      in_data   = (state_q == StData);
      mem_fetch = in_fetch;
      mem_read  = !err_q && (in_fetch || (in_data && !we_q));
      mem_write = !err_q && in_data && we_q;
      mem_half  = !err_q && in_data && (size_q == 2'b01);
      mem_byte  = !err_q && in_data && (size_q == 2'b00);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
   end

   always_comb begin
      unique case (size_q)
         2'b00:   load_ext = uns_q ? {24'b0, mem_rdata[7:0]}
                                   : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         2'b01:   load_ext = uns_q ? {16'b0, mem_rdata[15:0]}
                                   : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         last_data_q <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         err_q       <= 1'b0;
         if_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         dm_err_q    <= 1'b0;
         if_instr_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         if_ack_q <= 1'b0;
         if_err_q <= 1'b0;
         dm_ack_q <= 1'b0;
         dm_err_q <= 1'b0;
         if (grant_f) begin
            addr_q      <= if_addr;
            size_q      <= 2'b10;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= f_err;
            last_data_q <= 1'b0;
         end
         if (grant_d) begin
            addr_q      <= dm_addr;
            size_q      <= dm_size;
            we_q        <= dm_we;
            uns_q       <= dm_unsigned;
            wdata_q     <= dm_wdata;
            err_q       <= d_err;
            last_data_q <= 1'b1;
         end
         if (in_fetch) begin
            if_ack_q <= 1'b1;
            if_err_q <= err_q;
            if (!err_q) if_instr_q <= mem_rdata;
         end
         if (in_data) begin
            dm_ack_q <= 1'b1;
            dm_err_q <= err_q;
            if (!err_q) dm_rdata_q <= we_q ? 32'd0 : load_ext;
         end
      end
   end

   assign if_ack   = if_ack_q;
   assign if_err   = if_err_q;
   assign if_instr = if_instr_q;
   assign dm_ack   = dm_ack_q;
   assign dm_err   = dm_err_q;
   assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: byte-array memory, byte-level reference
// model, directed corner cases plus concurrent randomized fetch/data traffic.
module tb_mem_port_ctrl;
   localparam int unsigned MB = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_ack, if_err;
   logic [31:0] if_addr, if_instr;
   logic        dm_req, dm_we, dm_unsigned, dm_ack, dm_err;
   logic [1:0]  dm_size;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, mem_half, mem_byte, mem_fetch;

   mem_port_ctrl #(.MEM_BYTES(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err),
      .if_instr(if_instr),
      .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_err(dm_err),
      .dm_rdata(dm_rdata),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_half(mem_half), .mem_byte(mem_byte), .mem_fetch(mem_fetch),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] phys [MB];
   logic [7:0] ref_mem [MB];

   always @* begin
      mem_rdata = '0;
      for (int k = 0; k < 4; k++)
         if (longint'(mem_addr) + k < MB) mem_rdata[8*k +: 8] = phys[mem_addr + k];
   end

   always @(posedge clk) begin
      if (mem_write) begin
         for (int k = 0; k < (mem_byte ? 1 : mem_half ? 2 : 4); k++)
            if (longint'(mem_addr) + k < MB) phys[mem_addr + k] <= mem_wdata[8*k +: 8];
      end
   end

   typedef struct {
      logic        err;
      logic [31:0] val;
   } exp_t;

   exp_t        fq[$];
   exp_t        dq[$];
   int          checks = 0;
   int          passes = 0;
   bit          sb_en = 1'b0;
   int          obs_strobes = 0;
   int          exp_strobes = 0;
   int          wr_half4 = 0;
   logic [31:0] exp_if_prev = '0;
   logic [31:0] exp_dm_prev = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: pops an expectation whenever an ack appears.
   always @(negedge clk) begin
      exp_t e;
      if (sb_en) begin
         if (if_ack) begin
            if (fq.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
            else begin
               e = fq.pop_front();
               chk("if_err", {31'b0, if_err}, {31'b0, e.err});
               chk("if_instr", if_instr, e.val);
            end
         end
         if (dm_ack) begin
            if (dq.size() == 0) chk("dm_ack_unexpected", 32'd1, 32'd0);
            else begin
               e = dq.pop_front();
               chk("dm_err", {31'b0, dm_err}, {31'b0, e.err});
               chk("dm_rdata", dm_rdata, e.val);
            end
         end
         if (mem_read || mem_write) obs_strobes++;
         if (mem_write && mem_half && mem_addr == 32'd4) wr_half4++;
      end
   end

   task automatic wait_ack(input bit is_data);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(is_data ? dm_ack : if_ack) && n < 30);
      if (!(is_data ? dm_ack : if_ack)) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_fetch(input logic [31:0] a);
      exp_t e;
      e.err = (a[1:0] != 2'b00) || (longint'(a) + 3 >= MB);
      if (!e.err) begin
         e.val = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
         exp_strobes++;
      end else e.val = exp_if_prev;
      exp_if_prev = e.val;
      fq.push_back(e);
      if_addr = a;
      if_req  = 1'b1;
      wait_ack(1'b0);
      if_req  = 1'b0;
   endtask

   task automatic do_data(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd);
      exp_t        e;
      int          n;
      logic [31:0] raw, mask;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
           || (longint'(a) + n - 1 >= MB);
      if (!e.err) begin
         exp_strobes++;
         if (we) begin
            for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
            e.val = '0;
         end else begin
            raw  = '0;
            for (int k = 0; k < n; k++) raw[8*k +: 8] = ref_mem[a + k];
            mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
            e.val = raw & mask;
            if (!uns && n < 4 && raw[8*n - 1]) e.val = e.val | ~mask;
         end
      end else e.val = exp_dm_prev;
      exp_dm_prev = e.val;
      dq.push_back(e);
      dm_we = we; dm_size = sz; dm_unsigned = uns; dm_addr = a; dm_wdata = wd;
      dm_req = 1'b1;
      wait_ack(1'b1);
      dm_req = 1'b0;
   endtask

   // Both requesters held high from just after reset: grants go F,D,F,D.
   task automatic tie_test();
      logic [31:0] w;
      w = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
      if_addr = 32'd0;
      dm_we = 1'b0; dm_size = 2'd0; dm_unsigned = 1'b1; dm_addr = 32'd16; dm_wdata = '0;
      if_req = 1'b1; dm_req = 1'b1;
      @(negedge clk);
      chk("tie_c1_fetch", {31'b0, mem_fetch && mem_read}, 32'd1);
      @(negedge clk);
      chk("tie_c2_if_ack", {31'b0, if_ack}, 32'd1);
      chk("tie_c2_instr", if_instr, w);
      chk("tie_c2_idle", {30'b0, mem_fetch, mem_read}, 32'd0);
      @(negedge clk);
      chk("tie_c3_data", {30'b0, mem_fetch, mem_read}, 32'd1);
      @(negedge clk);
      chk("tie_c4_dm_ack", {31'b0, dm_ack}, 32'd1);
      chk("tie_c4_rdata", dm_rdata, {24'b0, ref_mem[16]});
      @(negedge clk);
      chk("tie_c5_fetch", {31'b0, mem_fetch}, 32'd1);
      @(negedge clk);
      chk("tie_c6_if_ack", {31'b0, if_ack}, 32'd1);
      @(negedge clk);
      chk("tie_c7_data", {30'b0, mem_fetch, mem_read}, 32'd1);
      if_req = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      chk("tie_c8_dm_ack", {31'b0, dm_ack}, 32'd1);
      repeat (2) @(negedge clk);
      exp_if_prev = w;
      exp_dm_prev = {24'b0, ref_mem[16]};
   endtask

   initial begin
      int s0, w0, acks;
      rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_size = '0; dm_unsigned = 1'b0;
      dm_addr = '0; dm_wdata = '0;
      for (int i = 0; i < MB; i++) begin
         ref_mem[i] = 8'($urandom);
         phys[i]    = ref_mem[i];
      end
      ref_mem[0] = 8'hFF; ref_mem[1] = 8'h54; ref_mem[2] = 8'h01; ref_mem[3] = 8'h02;
      ref_mem[6] = 8'h10; ref_mem[7] = 8'h82;
      for (int i = 0; i < 8; i++) phys[i] = ref_mem[i];
      repeat (2) @(negedge clk);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_strobes", {27'b0, mem_read, mem_write, mem_half, mem_byte, mem_fetch}, 32'd0);
      chk("rst_acks", {28'b0, if_ack, if_err, dm_ack, dm_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      tie_test();
      sb_en = 1'b1;

      do_fetch(32'd0);
      chk("fetch0_instr", if_instr, 32'h0201_54FF);
      do_data(1'b0, 2'd0, 1'b0, 32'd0, '0);
      chk("lb_signed", dm_rdata, 32'hFFFF_FFFF);
      do_data(1'b0, 2'd0, 1'b1, 32'd0, '0);
      chk("lb_unsigned", dm_rdata, 32'h0000_00FF);
      do_data(1'b0, 2'd1, 1'b0, 32'd6, '0);
      chk("lh_signed", dm_rdata, 32'hFFFF_8210);

      w0 = wr_half4;
      do_data(1'b1, 2'd1, 1'b0, 32'd4, 32'h0000_BEEF);
      chk("sh_rdata_zero", dm_rdata, 32'd0);
      chk("sh_one_write", 32'(wr_half4 - w0), 32'd1);
      do_data(1'b0, 2'd1, 1'b1, 32'd4, '0);
      chk("lhu_readback", dm_rdata, 32'h0000_BEEF);

      s0 = obs_strobes;
      do_data(1'b0, 2'd2, 1'b0, 32'd2, '0);
      do_data(1'b0, 2'd1, 1'b0, 32'd3, '0);
      do_data(1'b0, 2'd3, 1'b0, 32'd0, '0);
      do_data(1'b1, 2'd2, 1'b0, MB - 2, 32'h1234_5678);
      do_fetch(32'd2);
      do_fetch(MB - 2);
      chk("err_no_strobe", 32'(obs_strobes - s0), 32'd0);
      chk("err_rdata_kept", dm_rdata, 32'h0000_BEEF);

      fork
         begin
            for (int i = 0; i < 60; i++) begin
               logic [31:0] a;
               repeat ($urandom_range(0, 3)) @(negedge clk);
               a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 127))
                                                : 32'($urandom_range(0, 31) * 4);
               do_fetch(a);
            end
         end
         begin
            for (int j = 0; j < 60; j++) begin
               logic [31:0] a;
               repeat ($urandom_range(0, 3)) @(negedge clk);
               a = ($urandom_range(0, 9) == 0) ? 32'(MB + $urandom_range(0, 1000))
                                                : 32'($urandom_range(128, MB - 1));
               do_data(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            end
         end
      join
      repeat (3) @(negedge clk);
      chk("strobe_count", 32'(obs_strobes), 32'(exp_strobes));
      chk("fq_empty", 32'(fq.size()), 32'd0);
      chk("dq_empty", 32'(dq.size()), 32'd0);

      // Reset in the middle of a store's DATA cycle.
      sb_en = 1'b0;
      dm_we = 1'b1; dm_size = 2'd0; dm_unsigned = 1'b0; dm_addr = 32'd200;
      dm_wdata = 32'hA5; dm_req = 1'b1;
      @(negedge clk);
      chk("mid_rst_write_before", {31'b0, mem_write}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_write_drop", {30'b0, mem_write, mem_read}, 32'd0);
      dm_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (dm_ack || if_ack) acks++;
      end
      chk("mid_rst_no_ack", 32'(acks), 32'd0);
      chk("mid_rst_no_store", {24'b0, phys[200]}, {24'b0, ref_mem[200]});
      tie_test();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
